// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetches 16-bit instruction words from program memory one at a time and
// presents them to the decode stage. Holds the fetch program counter,
// redirects on control-flow branches and stops for good once the decoder
// accepts an instruction it flags as illegal. Every output is decoded from
// registered state only, so memory and decoder inputs never reach an output
// combinationally.
module instruction_fetch_unit #(
  parameter logic [14:0] RESET_ADDRESS = 15'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_request,
  output logic [14:0] mem_address,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] instruction,
  output logic        instruction_valid,
  input  logic        instruction_accept,
  input  logic        illegal_instruction,
  input  logic        branch_valid,
  input  logic [14:0] branch_address,
  output logic [14:0] program_counter,
  output logic        halted
);

  // State encoding, kept as plain constants for compatibility with older tools.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [14:0] fetch_pc_r;
  logic [15:0] instruction_r;
  logic [14:0] program_counter_r;

  // Datapath strobes derived from the current state and this cycle's inputs.
  logic load_branch_s;
  logic capture_s;
  logic illegal_accept_s;

  // Next-state selection and datapath strobes.
  always_comb begin
    state_next_s     = state_r;
    load_branch_s    = 1'b0;
    capture_s        = 1'b0;
    illegal_accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A fresh request is always issued out of IDLE; a branch seen here
        // simply retargets that first request.
        state_next_s  = ST_FETCH;
        load_branch_s = branch_valid;
      end
      ST_FETCH: begin
        if (branch_valid) begin
          // The redirect wins over any word returned this cycle.
          load_branch_s = 1'b1;
          state_next_s  = ST_FETCH;
        end else if (mem_ready) begin
          capture_s    = 1'b1;
          state_next_s = ST_PRESENT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_PRESENT: begin
        // The illegal verdict only matters when the word is actually taken.
        illegal_accept_s = instruction_accept & illegal_instruction;
        if (illegal_accept_s) begin
          state_next_s = ST_HALT;
        end else if (branch_valid) begin
          load_branch_s = 1'b1;
          state_next_s  = ST_FETCH;
        end else if (instruction_accept) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_PRESENT;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        // Unreachable encodings fall into the safe halted state.
        state_next_s = ST_HALT;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetch program counter: branch target, post-increment on capture, else hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_ADDRESS;
    end else if (load_branch_s) begin
      fetch_pc_r <= branch_address;
    end else if (capture_s) begin
      // 15-bit addition wraps 7FFF back to 0000 naturally.
      fetch_pc_r <= fetch_pc_r + 15'd1;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Presented instruction and its address, loaded only when memory answers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction_r     <= 16'h0000;
      program_counter_r <= RESET_ADDRESS;
    end else if (capture_s) begin
      instruction_r     <= mem_data;
      program_counter_r <= fetch_pc_r;
    end else begin
      instruction_r     <= instruction_r;
      program_counter_r <= program_counter_r;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_request       = 1'b0;
    instruction_valid = 1'b0;
    halted            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_request = 1'b0;
      end
      ST_FETCH: begin
        mem_request = 1'b1;
      end
      ST_PRESENT: begin
        instruction_valid = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  assign mem_address     = fetch_pc_r;
  assign instruction     = instruction_r;
  assign program_counter = program_counter_r;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetches 16-bit instructions from program memory and hands them, one at a time, to the socket array stage that decodes them into unit actions. Holds the fetch program counter and redirects it on branches reported by the control-flow unit. Halts permanently when the decode stage flags an illegal instruction. Sits directly upstream of the socket array stage, between program memory and the decoder.

## Interface
- `RESET_ADDRESS`, default 15'h0000: word address fetched first after reset.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_request`  out  1  read request to program memory.
- `mem_address`  out  15  word address of the requested instruction.
- `mem_ready`  in  1  memory returns `mem_data` this cycle.
- `mem_data`  in  16  instruction word; valid only when `mem_ready`=1.
- `instruction`  out  16  instruction presented to the decode stage.
- `instruction_valid`  out  1  `instruction` is valid.
- `instruction_accept`  in  1  decode stage consumes `instruction` this cycle.
- `illegal_instruction`  in  1  decode verdict for the presented instruction.
- `branch_valid`  in  1  control-flow unit requests a redirect.
- `branch_address`  in  15  redirect target, word address.
- `program_counter`  out  15  address of the word currently in `instruction`.
- `halted`  out  1  unit is halted.

## Operation
- Registers: `state` in {IDLE, FETCH, PRESENT, HALT}; `fetch_pc`[14:0]; `instruction`[15:0]; `program_counter`[14:0].
- Reset (async, `reset`=0): state=IDLE, `fetch_pc`=RESET_ADDRESS, `instruction`=16'h0000, `program_counter`=RESET_ADDRESS. Outputs: `mem_request`=0, `mem_address`=RESET_ADDRESS, `instruction_valid`=0, `halted`=0.
- IDLE: no request. Next cycle goes to FETCH unconditionally, unless `branch_valid`=1, in which case `fetch_pc`<=`branch_address` and the state still goes to FETCH.
- FETCH: `mem_request`=1, `mem_address`=`fetch_pc`; address held stable until `mem_ready`.
  - If `branch_valid`=1: `fetch_pc`<=`branch_address`, stay in FETCH, discard any `mem_data` returned that cycle.
  - Else if `mem_ready`=1: `instruction`<=`mem_data`, `program_counter`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1 mod 2^15 (7FFF wraps to 0000), go to PRESENT.
  - Else stay in FETCH.
- PRESENT: `instruction_valid`=1, `mem_request`=0. Priority, highest first:
  - `instruction_accept`=1 and `illegal_instruction`=1: go to HALT. Any branch is ignored.
  - `branch_valid`=1, with or without accept: `fetch_pc`<=`branch_address`, go to FETCH. An unaccepted instruction is dropped.
  - `instruction_accept`=1: go to FETCH.
  - Otherwise hold. `instruction` and `program_counter` stay stable.
- `illegal_instruction` is ignored unless `instruction_valid`=1 and `instruction_accept`=1.
- HALT: `halted`=1, `instruction_valid`=0, `mem_request`=0. `branch_valid` is ignored. Only `reset` exits HALT.
- Instruction contents are not interpreted. The no-op encoding 16'h0100 and all other encodings pass through unchanged.

## Timing
- `mem_request`, `mem_address`, `instruction_valid` and `halted` are decoded from registered state only. They have no combinational path from any input.
- Memory may take any number of wait cycles. The request must not drop, and the address must not change, while waiting, except on a branch redirect.
- Best case: 2 cycles per instruction (FETCH with `mem_ready`=1, then PRESENT with accept). Sustained throughput is 1 instruction per 2 cycles.
- A branch accepted in cycle N puts `branch_address` on `mem_address` in cycle N+1.
- `instruction_valid` rises exactly one cycle after the FETCH cycle in which `mem_ready`=1.
- HALT is entered on the edge after the illegal accept; `halted`=1 from the next cycle.
- Reset asserted mid-fetch or mid-present takes effect immediately. Any outstanding memory response after reset release is not awaited: IDLE issues a fresh request.

## Test plan
- Reset release with RESET_ADDRESS=15'h0010, memory with zero wait returning 16'h0180 then 16'h0D81, decoder accepting at once -> `mem_address` 0010 then 0011; instructions presented in order with `program_counter` 0010, 0011; `instruction_valid` every other cycle.
- Memory with 3 wait cycles -> `mem_request` held high and `mem_address` stable for 4 cycles; `instruction_valid` rises the cycle after `mem_ready`.
- Decoder holds `instruction_accept`=0 for 5 cycles -> `instruction` and `program_counter` unchanged; no new `mem_request` until accept.
- `branch_valid`=1 with `branch_address`=15'h1234 in the same cycle as accept of the word at 0003 -> next `mem_address`=1234; word at 0004 never requested. Repeat with the branch during a FETCH cycle where `mem_ready`=1 -> returned word discarded, `instruction_valid` stays 0.
- `fetch_pc` at 15'h7FFF -> after that fetch the next `mem_address` is 15'h0000.
- Accept with `illegal_instruction`=1 and `branch_valid`=1 together -> HALT: `halted`=1, no further `mem_request`, branch ignored; a later `reset` pulse restarts at RESET_ADDRESS with `halted`=0.
